// File: rtl/entity_sched_pkg.sv
// Shared widths, the empty-slot descriptor and the scheduler FSM state type.
package entity_sched_pkg;

  localparam int ENTITY_W = 14;
  localparam int SLOT_W   = 4;

  // Descriptor with ID 4'hF and tile 0: what the frame buffer shows as "no entity".
  localparam logic [ENTITY_W-1:0] EMPTY_ENTITY = 14'h3C00;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_COMMIT,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/entity_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         grant
);

  int   idx;
  logic found;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/entity_update_scheduler.sv
// Entity update scheduler: arbitrates descriptor writes into the frame-buffer slot banks.
// Define ENTITY_SCHED_VBLANK_SYNC_EN to stage writes in a shadow bank committed on vblank.
module entity_update_scheduler
  import entity_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int N_SLOTS = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [SLOT_W*N_REQ-1:0]       req_slot,
  input  logic [ENTITY_W*N_REQ-1:0]     req_entity,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          vblank,
  input  logic                          flush,
  output logic [ENTITY_W*N_SLOTS-1:0]   entity_out,
  output logic                          busy,
  output logic                          err_slot
);

  localparam int PTR_W = $clog2(N_REQ);

  state_t              state, state_next;
  logic [PTR_W-1:0]    rr_ptr, g_idx, next_ptr;
  logic [N_REQ-1:0]    grant;
  logic [SLOT_W-1:0]   clr_cnt, sel_slot;
  logic [ENTITY_W-1:0] sel_entity;
  logic                xfer, slot_ok, wr_en, vblank_edge, commit_en;

  logic [ENTITY_W-1:0] active [N_SLOTS];

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb req_ready = (state == ST_RUN && !reset) ? grant : '0;

  always_comb begin
    xfer       = 1'b0;
    g_idx      = '0;
    sel_slot   = '0;
    sel_entity = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        xfer       = 1'b1;
        g_idx      = PTR_W'(i);
        sel_slot   = req_slot[SLOT_W*i +: SLOT_W];
        sel_entity = req_entity[ENTITY_W*i +: ENTITY_W];
      end
    end
  end

  assign slot_ok  = sel_slot < SLOT_W'(N_SLOTS);
  assign wr_en    = xfer && slot_ok;
  assign next_ptr = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
  logic                vblank_q;
  logic [ENTITY_W-1:0] shadow [N_SLOTS];

  always_ff @(posedge clk) begin
    if (reset) vblank_q <= 1'b0;
    else       vblank_q <= vblank;
  end

  assign vblank_edge = vblank && !vblank_q;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign vblank_edge   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (flush)            state_next = ST_CLEAR;
        else if (vblank_edge) state_next = ST_COMMIT;
      end
      ST_COMMIT: state_next = flush ? ST_CLEAR : ST_RUN;
      ST_CLEAR:  if (clr_cnt == SLOT_W'(N_SLOTS - 1)) state_next = ST_RUN;
      default:   state_next = ST_RUN;
    endcase
  end

  // A flush arriving during COMMIT discards the copy.
  assign commit_en = (state == ST_COMMIT) && !flush;
  assign busy      = (state != ST_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RUN;
      rr_ptr   <= '0;
      err_slot <= 1'b0;
      clr_cnt  <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      if (xfer) rr_ptr <= next_ptr;
      if (state != ST_CLEAR && state_next == ST_CLEAR) err_slot <= 1'b0;
      else if (xfer && !slot_ok)                       err_slot <= 1'b1;
    end
  end

  // NOTE: the slot banks are reset explicitly because the frame buffer must see empty slots after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_SLOTS; k++) begin
        active[k] <= EMPTY_ENTITY;
`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
        shadow[k] <= EMPTY_ENTITY;
`endif
      end
    end else if (state == ST_CLEAR) begin
      active[clr_cnt] <= EMPTY_ENTITY;
`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
      shadow[clr_cnt] <= EMPTY_ENTITY;
`endif
    end else begin
`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
      if (wr_en) shadow[sel_slot] <= sel_entity;
      if (commit_en) begin
        for (int k = 0; k < N_SLOTS; k++) active[k] <= shadow[k];
      end
`else
      if (wr_en || commit_en) active[sel_slot] <= sel_entity;
`endif
    end
  end

  for (genvar k = 0; k < N_SLOTS; k++) begin : g_out
    assign entity_out[ENTITY_W*k +: ENTITY_W] = active[k];
  end

endmodule

// File: tb/tb_entity_update_scheduler.sv
// Scoreboarded bench for entity_update_scheduler; follows ENTITY_SCHED_VBLANK_SYNC_EN like the RTL.
module tb_entity_update_scheduler;
  localparam int NR = 4;
  localparam int NS = 9;
  localparam logic [13:0] EMPTY = 14'h3C00;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [4*NR-1:0]   req_slot;
  logic [14*NR-1:0]  req_entity;
  logic [NR-1:0]     req_ready;
  logic              vblank, flush, busy, err_slot;
  logic [14*NS-1:0]  entity_out;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic [13:0] ent [NR];

  entity_update_scheduler #(.N_REQ(NR), .N_SLOTS(NS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_slot   (req_slot),
    .req_entity (req_entity),
    .req_ready  (req_ready),
    .vblank     (vblank),
    .flush      (flush),
    .entity_out (entity_out),
    .busy       (busy),
    .err_slot   (err_slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [13:0] slot_val(input int k);
    return entity_out[14*k +: 14];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_empty(input string name);
    for (int k = 0; k < NS; k++) check($sformatf("%s_slot%0d", name, k), slot_val(k), EMPTY);
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check(name, n, 9);
  endtask

  // Monitor: every accepted handshake is compared with the next expected grant.
  always @(negedge clk) begin
    if (!reset && |(req_valid & req_ready)) begin
      int g = -1;
      for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) g = i;
      check("ready_onehot", $countones(req_ready), 1);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL grant_unexpected actual=%0d expected=none", g);
      end else begin
        check("grant", g, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) ent[i] = 14'(14'h0400 * (i + 1) + 14'h0011 * i);
    reset = 1'b1; req_valid = '1; req_slot = '0; req_entity = '0;
    vblank = 1'b0; flush = 1'b0;

    repeat (3) tick();
    check("ready_in_reset", req_ready, 0);
    check("busy_in_reset", busy, 0);

    reset = 1'b0; req_valid = '0;
    repeat (5) tick();
    check_all_empty("idle");
    check("idle_err", err_slot, 0);
    check("idle_ready", req_ready, 0);
    check("idle_busy", busy, 0);

    // All requesters continuously valid: grants 0,1,2,3,0.
    for (int i = 0; i < NR; i++) begin
      req_slot[4*i +: 4]    = 4'(i);
      req_entity[14*i +: 14] = ent[i];
    end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    req_valid = 4'hF;
    repeat (5) tick();
    req_valid = '0;
`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
    for (int i = 0; i < NR; i++) check($sformatf("shadow_hidden%0d", i), slot_val(i), EMPTY);
    vblank = 1'b1;
    tick();
    check("commit_busy", busy, 1);
    tick();
    vblank = 1'b0;
    for (int i = 0; i < NR; i++) check($sformatf("committed%0d", i), slot_val(i), ent[i]);
`else
    for (int i = 0; i < NR; i++) check($sformatf("direct%0d", i), slot_val(i), ent[i]);
    vblank = 1'b1;
    tick();
    check("vblank_ignored_busy", busy, 0);
    tick();
    vblank = 1'b0;
`endif
    check("grant_queue_drained", exp_q.size(), 0);

    // Flush clears everything over 9 cycles.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    count_clear("clear_cycles_1");
    check_all_empty("flush1");

    // Out-of-range slot: handshake completes, nothing written, sticky error.
    req_slot[8 +: 4] = 4'd9; req_entity[28 +: 14] = 14'h1234;
    exp_q.push_back(2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    check("err_set", err_slot, 1);
    repeat (2) tick();
    check("err_sticky", err_slot, 1);
    check_all_empty("badslot");

    // Pending write then flush coincident with a vblank edge: no commit.
    req_slot[4 +: 4] = 4'd1; req_entity[14 +: 14] = 14'h2AAA;
    exp_q.push_back(1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    vblank = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("err_cleared", err_slot, 0);
    count_clear("clear_cycles_2");
    check_all_empty("flush2");
    repeat (3) tick();
    check("no_commit_slot1", slot_val(1), EMPTY);
    check("no_commit_busy", busy, 0);
    vblank = 1'b0;
    tick();

`ifdef ENTITY_SCHED_VBLANK_SYNC_EN
    // Write slot 2, vblank rises 3 cycles later, visible 2 cycles after the edge.
    req_slot[8 +: 4] = 4'd2; req_entity[28 +: 14] = 14'h0512;
    exp_q.push_back(2);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (2) tick();
    vblank = 1'b1;
    check("pre_edge_slot2", slot_val(2), EMPTY);
    check("pre_edge_busy", busy, 0);
    tick();
    check("edge1_slot2", slot_val(2), EMPTY);
    check("edge1_busy", busy, 1);
    tick();
    check("edge2_slot2", slot_val(2), 14'h0512);
    check("edge2_busy", busy, 0);
    vblank = 1'b0;
    tick();
`else
    // Direct write: slot 0 updates one cycle after the transfer with vblank low.
    req_slot[0 +: 4] = 4'd0; req_entity[0 +: 14] = 14'h0A07;
    exp_q.push_back(0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    check("direct_slot0", slot_val(0), 14'h0A07);
    check("direct_slot1", slot_val(1), EMPTY);
    check("direct_busy", busy, 0);
    tick();
`endif
    check("final_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/entity_update_scheduler.md
ENTITY_UPDATE_SCHEDULER -- requirements
Module: entity_update_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of entity-update requesters (2..8).
REQ-002 Parameter N_SLOTS, default 9, number of frame-buffer entity slots (1..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester write request.
REQ-006 req_slot  input  4*N_REQ  per-requester target slot index, requester i at [4i+3:4i].
REQ-007 req_entity  input  14*N_REQ  per-requester descriptor {ID[13:10], orientation[9:8], tile[7:0]}, requester i at [14i+13:14i].
REQ-008 req_ready  output  N_REQ  one-hot (or zero) accept; transfer when req_valid[i] & req_ready[i].
REQ-009 vblank  input  1  vertical-blank level from the VGA timing block.
REQ-010 flush  input  1  single-cycle request to clear all slots.
REQ-011 entity_out  output  14*N_SLOTS  active descriptors to the frame buffer, slot k at [14k+13:14k].
REQ-012 busy  output  1  high in COMMIT or CLEAR state.
REQ-013 err_slot  output  1  sticky: a transfer with req_slot >= N_SLOTS occurred.

Function
REQ-014 Block SHALL hold a shadow bank and an active bank of N_SLOTS 14-bit descriptors; entity_out SHALL be the active bank, registered.
REQ-015 FSM states: RUN, COMMIT, CLEAR; reset enters RUN.
REQ-016 In RUN, round-robin grant SHALL pick the first valid requester at or after pointer rr_ptr (wrapping N_REQ-1 -> 0); req_ready SHALL be combinational from that grant; all req_ready low outside RUN.
REQ-017 After a transfer by requester g, rr_ptr SHALL become (g+1) mod N_REQ; without transfer rr_ptr SHALL hold.
REQ-018 At most one transfer per cycle; a transfer SHALL write req_entity into shadow[req_slot] at that clock edge (last write wins for repeated slots).
REQ-019 A transfer with req_slot >= N_SLOTS SHALL complete the handshake, write nothing, and set err_slot.
REQ-020 A vblank rising edge (vblank high, registered vblank low) seen in RUN with flush low SHALL move the FSM to COMMIT next cycle; a transfer in the edge cycle SHALL be included in that commit.
REQ-021 COMMIT SHALL last exactly one cycle, copy shadow to active, then return to RUN; latency vblank edge -> entity_out updated = 2 cycles.
REQ-022 flush in RUN or COMMIT SHALL enter CLEAR; flush has priority over a simultaneous vblank edge or COMMIT copy, and that commit is discarded.
REQ-023 CLEAR SHALL walk slot counter 0..N_SLOTS-1, one slot per cycle, writing 14'h3C00 into both shadow and active, clearing err_slot on entry, then return to RUN (N_SLOTS cycles); vblank edges and flush during CLEAR are ignored.

Reset
REQ-024 Reset SHALL set every shadow and active slot to 14'h3C00, rr_ptr=0, state RUN, req_ready=0 during reset, busy=0, err_slot=0, registered vblank=0.
REQ-025 Reset asserted mid-COMMIT or mid-CLEAR SHALL abort it and apply REQ-024 at the next edge.

Configuration
REQ-026 With ENTITY_SCHED_VBLANK_SYNC_EN defined, the shadow bank and COMMIT behaviour SHALL be as above.
REQ-027 Without ENTITY_SCHED_VBLANK_SYNC_EN, no shadow bank SHALL exist, transfers SHALL write the active bank directly (entity_out updates 1 cycle after transfer), vblank SHALL be ignored and COMMIT SHALL be unreachable.

Structure
REQ-028 Package entity_sched_pkg SHALL hold ENTITY_W=14, SLOT_W=4, EMPTY_ENTITY=14'h3C00 and the FSM state typedef.
REQ-029 Round-robin grant logic SHALL be a sub-module rr_arbiter (parameter N_REQ; inputs valid, ptr; output one-hot grant).

Verification
REQ-030 Reset, then idle 5 cycles -> every entity_out slot 14'h3C00, err_slot 0, req_ready all 0.
REQ-031 Requesters 0..3 all valid continuously to slots 0..3 -> grants in order 0,1,2,3,0, one per cycle.
REQ-032 Write 14'h0512 to slot 2, vblank rises 3 cycles later -> slot 2 still 14'h3C00 until 2 cycles after edge, then 14'h0512; busy high exactly 1 cycle.
REQ-033 Transfer to slot 9 (N_SLOTS=9) -> handshake completes, no slot changes, err_slot 1 until next flush.
REQ-034 flush in the same cycle as a vblank edge with pending shadow writes -> CLEAR for 9 cycles, busy high 9 cycles, all slots 14'h3C00, no commit.
REQ-035 Build without ENTITY_SCHED_VBLANK_SYNC_EN, write 14'h0A07 to slot 0 -> entity_out slot 0 equals 14'h0A07 one cycle later with vblank held low.
